// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: one full-adder cell plus a carry flop, start/busy/done handshake.
// Optional SERIAL_ADDER_OVF_EN adds a registered two's-complement overflow output (ovf).
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  // state   | meaning
  // S_IDLE  | waiting for start
  // S_SHIFT | one full-adder step per clock, LSB first
  // S_DONE  | result pulse cycle; a new start is accepted here as in S_IDLE
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             s_bit;
  logic             c_next;
  logic [WIDTH-1:0] sum_next;

  assign s_bit    = a_sr[0] ^ b_sr[0] ^ carry;
  assign c_next   = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));
  assign sum_next = {s_bit, sum_sr[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= S_SHIFT;
          end else begin
            state <= S_IDLE;
          end
        end
        S_SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          carry  <= c_next;
          sum_sr <= sum_next;
          cnt    <= cnt + CW'(1);
          // Outputs are loaded only here, so sum/cout never show a partial result
          if (cnt == LAST) begin
            sum   <= sum_next;
            cout  <= c_next;
`ifdef SERIAL_ADDER_OVF_EN
            ovf   <= carry ^ c_next;
`endif
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
